// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data, plus the fetch starvation counter.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic grant_taken_i,
  output logic win_if_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;

  // Data wins by default; a starved fetch is forced through once.
  always_comb begin
    win_if_o = if_req_i && (!d_req_i || (starve_q == SW'(STARVE_MAX)));
  end

  always_comb begin
    starve_d = starve_q;
    if (grant_taken_i) begin
      if (win_if_o) begin
        starve_d = '0;
      end else if (if_req_i && (starve_q != SW'(STARVE_MAX))) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-ported memory.
// Optional counters: define MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]   perf_if_grants,
  output logic [31:0]   perf_d_grants,
  output logic [31:0]   perf_if_wait_cycles
`endif
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic          take, win_if;

  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic          if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;
  logic          resp_if, resp_d;

  assign take = (state_q == IDLE) && (if_req || d_req);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk_i         (clk),
    .reset_i       (reset),
    .if_req_i      (if_req),
    .d_req_i       (d_req),
    .grant_taken_i (take),
    .win_if_o      (win_if)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE:  if (if_req || d_req) state_d = ISSUE;
      ISSUE: begin
        wait_d  = '0;
        state_d = (MEM_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        if (int'(wait_q) == MEM_LAT - 2) state_d = RESP;
        else                             wait_d  = wait_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded from the next state so they line up with it.
  always_comb begin
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    busy_d      = (state_d != IDLE);
    if (take) begin
      owner_d     = win_if ? OWN_IF : OWN_D;
      we_d        = !win_if && d_we;
      mem_addr_d  = win_if ? if_addr : d_addr;
      mem_wdata_d = win_if ? '0 : d_wdata;
      mem_en_d    = 1'b1;
      mem_we_d    = !win_if && d_we;
      if_gnt_d    = win_if;
      d_gnt_d     = !win_if;
    end
    if ((state_q != RESP) && (state_d == RESP)) begin
      if_rvalid_d = (owner_q == OWN_IF);
      d_rvalid_d  = (owner_q == OWN_D);
    end
    if (resp_if) if_rdata_d = mem_rdata;
    if (resp_d)  d_rdata_d  = we_q ? '0 : mem_rdata;
  end

  // The memory's output register feeds the core directly in the response cycle.
  assign resp_if   = (state_q == RESP) && (owner_q == OWN_IF);
  assign resp_d    = (state_q == RESP) && (owner_q == OWN_D);
  assign if_rdata  = resp_if ? mem_rdata : if_rdata_q;
  assign d_rdata   = resp_d ? (we_q ? '0 : mem_rdata) : d_rdata_q;
  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_ifg_q, perf_dg_q, perf_ifw_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_ifg_q <= '0;
      perf_dg_q  <= '0;
      perf_ifw_q <= '0;
    end else begin
      perf_ifg_q <= perf_ifg_q + {31'd0, if_gnt_q};
      perf_dg_q  <= perf_dg_q + {31'd0, d_gnt_q};
      perf_ifw_q <= perf_ifw_q + {31'd0, (if_req && !if_gnt_q)};
    end
  end

  assign perf_if_grants      = perf_ifg_q;
  assign perf_d_grants       = perf_dg_q;
  assign perf_if_wait_cycles = perf_ifw_q;
`endif

endmodule
